// File: rtl/systolic_writeback_if.sv
`default_nettype none
// ============================================================================
// systolic_writeback_if : output-SRAM write port (request/ready handshake)
// Rev 1.0
// ============================================================================
interface systolic_writeback_if #(
  parameter int ADDR_W = 7,
  parameter int DATA_W = 64
);
  logic              out_sram_wen;
  logic [ADDR_W-1:0] out_sram_addr;
  logic [DATA_W-1:0] out_sram_wdata;
  logic              out_sram_ready;

  modport master (
    output out_sram_wen,
    output out_sram_addr,
    output out_sram_wdata,
    input  out_sram_ready
  );

  modport slave (
    input  out_sram_wen,
    input  out_sram_addr,
    input  out_sram_wdata,
    output out_sram_ready
  );
endinterface
`default_nettype wire

// File: rtl/systolic_writeback.sv
`default_nettype none
// ============================================================================
// systolic_writeback : rounds/shifts/saturates accumulator rows to int8 and
// commits them to the output SRAM through a small first-word-fall-through FIFO.
// Rev 1.0
// ============================================================================
module systolic_writeback #(
  parameter int ARRAY_SIZE    = 8,
  parameter int ACC_W         = 20,
  parameter int K_ACCUM_DEPTH = 8,
  parameter int ADDR_W        = 7,
  parameter int FIFO_DEPTH    = 4
) (
  input  logic                          clk,
  input  logic                          srstn,
  input  logic                          sram_write_enable,
  input  logic [5:0]                    matrix_index,
  input  logic [5:0]                    data_set,
  input  logic [ARRAY_SIZE*ACC_W-1:0]   acc_in,
  input  logic [3:0]                    shift,
  input  logic                          tpu_done,
  systolic_writeback_if.master          sram_if,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic                          sat_flag,
  output logic                          overflow_err,
  output logic                          wb_done
);

  localparam int DATA_W = ARRAY_SIZE * 8;
  localparam int PTR_W  = $clog2(FIFO_DEPTH);
  localparam int LVL_W  = PTR_W + 1;
  localparam int ROWS   = K_ACCUM_DEPTH + 1;
  localparam logic signed [ACC_W:0] C_MAX = (ACC_W+1)'(127);
  localparam logic signed [ACC_W:0] C_MIN = (ACC_W+1)'(-128);

  // ---------------------------------------------------------------- S1 capture
  logic                        s1_valid_q;
  logic [ARRAY_SIZE*ACC_W-1:0] s1_acc_q;
  logic [ADDR_W-1:0]           s1_addr_q;
  logic [ADDR_W-1:0]           s1_addr_d;

  // Operands are truncated first; the result is identical modulo 2^ADDR_W.
  assign s1_addr_d = ADDR_W'(data_set) * ADDR_W'(ROWS) + ADDR_W'(matrix_index);

  always_ff @(posedge clk) begin
    if (!srstn) s1_valid_q <= 1'b0;
    else        s1_valid_q <= sram_write_enable;
  end

  always_ff @(posedge clk) begin
    if (sram_write_enable) begin
      s1_acc_q  <= acc_in;
      s1_addr_q <= s1_addr_d;
    end
  end

  // --------------------------------------------------------------- S2 quantize
  logic [DATA_W-1:0]     s2_row_d;
  logic [ARRAY_SIZE-1:0] lane_clip;

  for (genvar gi = 0; gi < ARRAY_SIZE; gi++) begin : g_lane
    logic signed [ACC_W:0] ext;
    logic signed [ACC_W:0] bias;
    logic signed [ACC_W:0] sum;
    logic signed [ACC_W:0] v;

    // One extra bit of headroom keeps the rounding add from wrapping.
    assign ext  = {s1_acc_q[gi*ACC_W+ACC_W-1], s1_acc_q[gi*ACC_W +: ACC_W]};
    assign bias = (shift == 4'd0) ? '0 : ((ACC_W+1)'(1) << (shift - 4'd1));
    assign sum  = ext + bias;
    assign v    = sum >>> shift;

    assign lane_clip[gi] = (v > C_MAX) || (v < C_MIN);
    assign s2_row_d[gi*8 +: 8] = (v > C_MAX) ? 8'h7F :
                                 (v < C_MIN) ? 8'h80 : v[7:0];
  end

  logic              s2_valid_q;
  logic [DATA_W-1:0] s2_row_q;
  logic [ADDR_W-1:0] s2_addr_q;
  logic              sat_q;

  always_ff @(posedge clk) begin
    if (!srstn) begin
      s2_valid_q <= 1'b0;
      sat_q      <= 1'b0;
    end else begin
      s2_valid_q <= s1_valid_q;
      if (s1_valid_q && (|lane_clip)) sat_q <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (s1_valid_q) begin
      s2_row_q  <= s2_row_d;
      s2_addr_q <= s1_addr_q;
    end
  end

  // --------------------------------------------------------------------- FIFO
  logic [DATA_W-1:0] mem_data_q [FIFO_DEPTH];
  logic [ADDR_W-1:0] mem_addr_q [FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q;
  logic [PTR_W-1:0]  rd_ptr_q;
  logic [LVL_W-1:0]  level_q;
  logic [LVL_W-1:0]  level_d;
  logic              ovf_q;
  logic              wen;
  logic              full;
  logic              pop;
  logic              push;
  logic              drop;

  assign wen  = (level_q != '0);
  assign full = (level_q == LVL_W'(FIFO_DEPTH));
  assign pop  = wen && sram_if.out_sram_ready;
  // A simultaneous pop frees the head slot, so a push into a full FIFO is legal.
  assign push = s2_valid_q && (!full || pop);
  assign drop = s2_valid_q && full && !pop;

  always_comb begin
    level_d = level_q;
    if (push && !pop)      level_d = level_q + LVL_W'(1);
    else if (pop && !push) level_d = level_q - LVL_W'(1);
  end

  always_ff @(posedge clk) begin
    if (!srstn) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      ovf_q    <= 1'b0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      level_q <= level_d;
      if (drop) ovf_q <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem_data_q[wr_ptr_q] <= s2_row_q;
      mem_addr_q[wr_ptr_q] <= s2_addr_q;
    end
  end

  assign sram_if.out_sram_wen   = wen;
  assign sram_if.out_sram_addr  = wen ? mem_addr_q[rd_ptr_q] : '0;
  assign sram_if.out_sram_wdata = wen ? mem_data_q[rd_ptr_q] : '0;

  // ---------------------------------------------------------------------- FSM
  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACTIVE = 2'd1,
    S_FLUSH  = 2'd2,
    S_DONE   = 2'd3
  } state_t;

  state_t state_q;
  logic   wb_done_q;

  always_ff @(posedge clk) begin
    if (!srstn) begin
      state_q   <= S_IDLE;
      wb_done_q <= 1'b0;
    end else begin
      wb_done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (tpu_done)               state_q <= S_FLUSH;
          else if (sram_write_enable) state_q <= S_ACTIVE;
        end
        S_ACTIVE: begin
          if (tpu_done) state_q <= S_FLUSH;
        end
        S_FLUSH: begin
          if (!s1_valid_q && !s2_valid_q && (level_q == '0)) begin
            state_q   <= S_DONE;
            wb_done_q <= 1'b1;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign fifo_level   = level_q;
  assign sat_flag     = sat_q;
  assign overflow_err = ovf_q;
  assign wb_done      = wb_done_q;

endmodule
`default_nettype wire

// File: tb/tb_systolic_writeback.sv
`default_nettype none
// ============================================================================
// tb_systolic_writeback : directed self-checking bench for systolic_writeback
// Rev 1.0
// ============================================================================
module tb_systolic_writeback;
  localparam int AS     = 8;
  localparam int AW     = 20;
  localparam int ADDR_W = 7;
  localparam int DW     = 64;

  logic             clk = 1'b0;
  logic             srstn;
  logic             swe;
  logic [5:0]       mi;
  logic [5:0]       ds;
  logic [AS*AW-1:0] acc;
  logic [3:0]       shift;
  logic             tpu_done;
  logic [2:0]       fifo_level;
  logic             sat_flag;
  logic             overflow_err;
  logic             wb_done;

  int checks   = 0;
  int failures = 0;

  systolic_writeback_if #(.ADDR_W(ADDR_W), .DATA_W(DW)) sram_if ();

  systolic_writeback dut (
    .clk               (clk),
    .srstn             (srstn),
    .sram_write_enable (swe),
    .matrix_index      (mi),
    .data_set          (ds),
    .acc_in            (acc),
    .shift             (shift),
    .tpu_done          (tpu_done),
    .sram_if           (sram_if),
    .fifo_level        (fifo_level),
    .sat_flag          (sat_flag),
    .overflow_err      (overflow_err),
    .wb_done           (wb_done)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_all(input int v);
    for (int i = 0; i < AS; i++) acc[i*AW +: AW] = AW'(v);
  endtask

  task automatic drive_row(input int d, input int m, input int v);
    swe = 1'b1;
    ds  = 6'(d);
    mi  = 6'(m);
    set_all(v);
  endtask

  task automatic apply_reset();
    srstn = 1'b0;
    swe = 1'b0;
    tpu_done = 1'b0;
    sram_if.out_sram_ready = 1'b0;
    tick();
    tick();
    srstn = 1'b1;
  endtask

  task automatic test_reset();
    apply_reset();
    checks++; if (sram_if.out_sram_wen !== 1'b0) begin failures++; $display("FAIL reset_wen got=%0b exp=0", sram_if.out_sram_wen); end
    checks++; if (sram_if.out_sram_addr !== 7'd0) begin failures++; $display("FAIL reset_addr got=%0d exp=0", sram_if.out_sram_addr); end
    checks++; if (sram_if.out_sram_wdata !== 64'd0) begin failures++; $display("FAIL reset_wdata got=%0h exp=0", sram_if.out_sram_wdata); end
    checks++; if (fifo_level !== 3'd0) begin failures++; $display("FAIL reset_level got=%0d exp=0", fifo_level); end
    checks++; if (sat_flag !== 1'b0) begin failures++; $display("FAIL reset_sat got=%0b exp=0", sat_flag); end
    checks++; if (overflow_err !== 1'b0) begin failures++; $display("FAIL reset_ovf got=%0b exp=0", overflow_err); end
    checks++; if (wb_done !== 1'b0) begin failures++; $display("FAIL reset_done got=%0b exp=0", wb_done); end
  endtask

  task automatic test_single_row();
    apply_reset();
    sram_if.out_sram_ready = 1'b1;
    shift = 4'd3;
    drive_row(0, 3, 1000);
    tick();
    swe = 1'b0;
    checks++; if (sram_if.out_sram_wen !== 1'b0) begin failures++; $display("FAIL single_wen_n got=%0b exp=0", sram_if.out_sram_wen); end
    tick();
    checks++; if (sram_if.out_sram_wen !== 1'b0) begin failures++; $display("FAIL single_wen_n1 got=%0b exp=0", sram_if.out_sram_wen); end
    tick();
    checks++; if (sram_if.out_sram_wen !== 1'b1) begin failures++; $display("FAIL single_wen_n2 got=%0b exp=1", sram_if.out_sram_wen); end
    checks++; if (sram_if.out_sram_addr !== 7'd3) begin failures++; $display("FAIL single_addr got=%0d exp=3", sram_if.out_sram_addr); end
    checks++; if (sram_if.out_sram_wdata !== 64'h7D7D7D7D7D7D7D7D) begin failures++; $display("FAIL single_data got=%0h exp=7d7d7d7d7d7d7d7d", sram_if.out_sram_wdata); end
    checks++; if (fifo_level !== 3'd1) begin failures++; $display("FAIL single_level1 got=%0d exp=1", fifo_level); end
    tick();
    checks++; if (fifo_level !== 3'd0) begin failures++; $display("FAIL single_level0 got=%0d exp=0", fifo_level); end
    checks++; if (sram_if.out_sram_wen !== 1'b0) begin failures++; $display("FAIL single_wen_after got=%0b exp=0", sram_if.out_sram_wen); end
    checks++; if (sat_flag !== 1'b0) begin failures++; $display("FAIL single_sat got=%0b exp=0", sat_flag); end
  endtask

  task automatic test_round_sat();
    int lv [AS] = '{23, -24, 2047, -2064, 0, 8, -8, 100000};
    apply_reset();
    sram_if.out_sram_ready = 1'b0;
    shift = 4'd4;
    swe = 1'b1;
    ds = 6'd0;
    mi = 6'd0;
    for (int i = 0; i < AS; i++) acc[i*AW +: AW] = AW'(lv[i]);
    tick();
    swe = 1'b0;
    tick();
    tick();
    checks++; if (sram_if.out_sram_wdata !== 64'h7F000100807FFF01) begin failures++; $display("FAIL round_data got=%0h exp=7f000100807fff01", sram_if.out_sram_wdata); end
    checks++; if (sat_flag !== 1'b1) begin failures++; $display("FAIL round_sat got=%0b exp=1", sat_flag); end
  endtask

  task automatic test_burst();
    logic [7:0] b;
    apply_reset();
    sram_if.out_sram_ready = 1'b1;
    shift = 4'd0;
    for (int t = 0; t <= 10; t++) begin
      if (t <= 8) drive_row(1, t, t);
      else swe = 1'b0;
      tick();
      if (t >= 2) begin
        b = 8'(t - 2);
        checks++; if (sram_if.out_sram_wen !== 1'b1) begin failures++; $display("FAIL burst_wen t=%0d got=%0b exp=1", t, sram_if.out_sram_wen); end
        checks++; if (sram_if.out_sram_addr !== 7'(9 + t - 2)) begin failures++; $display("FAIL burst_addr t=%0d got=%0d exp=%0d", t, sram_if.out_sram_addr, 9 + t - 2); end
        checks++; if (sram_if.out_sram_wdata !== {8{b}}) begin failures++; $display("FAIL burst_data t=%0d got=%0h exp=%0h", t, sram_if.out_sram_wdata, {8{b}}); end
      end
    end
    swe = 1'b0;
    tick();
    checks++; if (fifo_level !== 3'd0) begin failures++; $display("FAIL burst_level got=%0d exp=0", fifo_level); end
    checks++; if (overflow_err !== 1'b0) begin failures++; $display("FAIL burst_ovf got=%0b exp=0", overflow_err); end
  endtask

  task automatic test_backpressure();
    logic [7:0] b;
    apply_reset();
    sram_if.out_sram_ready = 1'b0;
    shift = 4'd0;
    for (int k = 0; k < 6; k++) begin
      drive_row(0, k, 10 + k);
      tick();
    end
    swe = 1'b0;
    tick();
    tick();
    checks++; if (fifo_level !== 3'd4) begin failures++; $display("FAIL bp_level got=%0d exp=4", fifo_level); end
    checks++; if (overflow_err !== 1'b1) begin failures++; $display("FAIL bp_ovf got=%0b exp=1", overflow_err); end
    for (int k = 0; k < 4; k++) begin
      b = 8'(10 + k);
      checks++; if (sram_if.out_sram_addr !== 7'(k) || sram_if.out_sram_wdata !== {8{b}}) begin failures++; $display("FAIL bp_head k=%0d got=%0d/%0h exp=%0d/%0h", k, sram_if.out_sram_addr, sram_if.out_sram_wdata, k, {8{b}}); end
      sram_if.out_sram_ready = 1'b0;
      tick();
      checks++; if (sram_if.out_sram_wen !== 1'b1 || sram_if.out_sram_addr !== 7'(k) || sram_if.out_sram_wdata !== {8{b}}) begin failures++; $display("FAIL bp_stall k=%0d got=%0b/%0d/%0h exp=1/%0d/%0h", k, sram_if.out_sram_wen, sram_if.out_sram_addr, sram_if.out_sram_wdata, k, {8{b}}); end
      sram_if.out_sram_ready = 1'b1;
      tick();
    end
    checks++; if (fifo_level !== 3'd0) begin failures++; $display("FAIL bp_drained got=%0d exp=0", fifo_level); end
    checks++; if (sram_if.out_sram_wen !== 1'b0) begin failures++; $display("FAIL bp_extra_write got=%0b exp=0", sram_if.out_sram_wen); end
  endtask

  task automatic test_full_push_pop();
    apply_reset();
    sram_if.out_sram_ready = 1'b0;
    shift = 4'd0;
    for (int k = 0; k < 5; k++) begin
      drive_row(0, k, k);
      tick();
    end
    swe = 1'b0;
    tick();
    checks++; if (fifo_level !== 3'd4) begin failures++; $display("FAIL fpp_full got=%0d exp=4", fifo_level); end
    sram_if.out_sram_ready = 1'b1;
    tick();
    checks++; if (fifo_level !== 3'd4) begin failures++; $display("FAIL fpp_level got=%0d exp=4", fifo_level); end
    checks++; if (overflow_err !== 1'b0) begin failures++; $display("FAIL fpp_ovf got=%0b exp=0", overflow_err); end
    for (int k = 1; k <= 4; k++) begin
      checks++; if (sram_if.out_sram_addr !== 7'(k)) begin failures++; $display("FAIL fpp_addr got=%0d exp=%0d", sram_if.out_sram_addr, k); end
      tick();
    end
    checks++; if (fifo_level !== 3'd0) begin failures++; $display("FAIL fpp_drained got=%0d exp=0", fifo_level); end
  endtask

  task automatic test_done();
    apply_reset();
    sram_if.out_sram_ready = 1'b0;
    shift = 4'd0;
    for (int k = 0; k < 3; k++) begin
      drive_row(2, k, k);
      tick();
    end
    swe = 1'b0;
    tick();
    tick();
    checks++; if (fifo_level !== 3'd3) begin failures++; $display("FAIL done_pending got=%0d exp=3", fifo_level); end
    tpu_done = 1'b1;
    tick();
    tpu_done = 1'b0;
    for (int s = 0; s < 5; s++) begin
      sram_if.out_sram_ready = (s % 2 == 0);
      tick();
      checks++; if (wb_done !== 1'b0) begin failures++; $display("FAIL done_early s=%0d got=%0b exp=0", s, wb_done); end
    end
    checks++; if (fifo_level !== 3'd0) begin failures++; $display("FAIL done_level got=%0d exp=0", fifo_level); end
    sram_if.out_sram_ready = 1'b0;
    tick();
    checks++; if (wb_done !== 1'b1) begin failures++; $display("FAIL done_pulse got=%0b exp=1", wb_done); end
    for (int s = 0; s < 3; s++) begin
      tick();
      checks++; if (wb_done !== 1'b0) begin failures++; $display("FAIL done_repeat s=%0d got=%0b exp=0", s, wb_done); end
    end
  endtask

  task automatic test_reset_mid_burst();
    apply_reset();
    sram_if.out_sram_ready = 1'b0;
    shift = 4'd0;
    for (int k = 0; k < 3; k++) begin
      drive_row(0, k, k);
      tick();
    end
    swe = 1'b0;
    tpu_done = 1'b1;
    tick();
    tpu_done = 1'b0;
    srstn = 1'b0;
    tick();
    checks++; if (sram_if.out_sram_wen !== 1'b0) begin failures++; $display("FAIL midrst_wen got=%0b exp=0", sram_if.out_sram_wen); end
    checks++; if (fifo_level !== 3'd0) begin failures++; $display("FAIL midrst_level got=%0d exp=0", fifo_level); end
    srstn = 1'b1;
    sram_if.out_sram_ready = 1'b1;
    for (int s = 0; s < 4; s++) begin
      tick();
      checks++; if (sram_if.out_sram_wen !== 1'b0 || wb_done !== 1'b0) begin failures++; $display("FAIL midrst_after s=%0d got=%0b/%0b exp=0/0", s, sram_if.out_sram_wen, wb_done); end
    end
  endtask

  initial begin
    srstn = 1'b0;
    swe = 1'b0;
    mi = '0;
    ds = '0;
    acc = '0;
    shift = '0;
    tpu_done = 1'b0;
    sram_if.out_sram_ready = 1'b0;
    test_reset();
    test_single_row();
    test_round_sat();
    test_burst();
    test_backpressure();
    test_full_push_pop();
    test_done();
    test_reset_mid_burst();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/systolic_writeback.md
Name: systolic_writeback

Overview:
Downstream stage of the systolic controller/array. It captures one accumulated result row per cycle while the controller asserts sram_write_enable, then rounds, shifts and saturates each lane to int8. Each packed row is queued in a small FIFO and written to the output SRAM through a ready handshake. It raises wb_done once tpu_done has been seen and every row has been committed.

Parameters:
ARRAY_SIZE, 8, lanes per result row
ACC_W, 20, signed accumulator width per lane
K_ACCUM_DEPTH, 8, rows per data set = K_ACCUM_DEPTH+1 (matrix_index 0..K_ACCUM_DEPTH)
ADDR_W, 7, output SRAM address width
FIFO_DEPTH, 4, row FIFO entries (power of 2)

Ports:
clk  in  1  clock
srstn  in  1  synchronous active-low reset
sram_write_enable  in  1  row valid from controller
matrix_index  in  6  row index within data set
data_set  in  6  data set index
acc_in  in  ARRAY_SIZE*ACC_W  lane i at bits [i*ACC_W +: ACC_W], signed
shift  in  4  quantize right-shift amount, static during a run
tpu_done  in  1  controller done pulse
out_sram_wen  out  1  write request
out_sram_addr  out  ADDR_W  write address
out_sram_wdata  out  ARRAY_SIZE*8  packed int8 row, lane i at [i*8 +: 8]
out_sram_ready  in  1  SRAM accepts write this cycle
fifo_level  out  3  occupied FIFO entries, 0..FIFO_DEPTH
sat_flag  out  1  sticky: any lane saturated
overflow_err  out  1  sticky: row dropped because FIFO was full
wb_done  out  1  one-cycle completion pulse

Behaviour:
- Reset (srstn=0 at posedge): all pipeline valids clear, FIFO emptied, FSM=IDLE. Outputs: out_sram_wen=0, out_sram_addr=0, out_sram_wdata=0, fifo_level=0, sat_flag=0, overflow_err=0, wb_done=0. Reset mid-run discards all in-flight rows, with no SRAM write after reset.
- S1 (capture): on a posedge with sram_write_enable=1, register acc_in and addr = data_set*(K_ACCUM_DEPTH+1) + matrix_index, truncated to ADDR_W. Set s1_valid.
- S2 (quantize, registered): per lane, if shift>0 then v = (acc + (1<<(shift-1))) >>> shift, otherwise v = acc. Arithmetic shift; compute at ACC_W+1 bits so the rounding add cannot overflow. Saturate v to [-128,127]. If any lane clips, set sat_flag.
- FIFO push: happens when s2_valid. FIFO is first-word fall-through: the head drives out_sram_addr/out_sram_wdata, and out_sram_wen = (fifo_level != 0).
- Latency: a row valid in cycle n, with the FIFO empty, appears with out_sram_wen=1 in cycle n+2.
- Pop: at a posedge with out_sram_wen && out_sram_ready. While ready=0, wen, addr and data hold stable.
- Push and pop in the same cycle: level unchanged. This is legal even when the FIFO is full, because the pop frees the slot.
- Push when full with no pop: the row is dropped, overflow_err is set, and the FIFO contents are unchanged.
- The pipeline accepts one row every cycle. There is no backpressure to the controller.
- FSM:
  - IDLE -> ACTIVE on sram_write_enable.
  - IDLE or ACTIVE -> FLUSH on tpu_done.
  - FLUSH -> DONE when s1_valid=0, s2_valid=0 and fifo_level=0.
  - DONE -> IDLE unconditionally. wb_done=1 only in DONE.
  - tpu_done in FLUSH or DONE is ignored. Rows arriving in FLUSH are still processed, and they delay DONE.
- sat_flag and overflow_err clear only on reset.

Test Plan:
- Single row, data_set=0, matrix_index=3, all lanes acc=1000, shift=3, ready=1: wen in cycle n+2, addr=3, every byte=125 (0x7D), then one pop, fifo_level returns to 0, sat_flag=0.
- Rounding and saturation, shift=4, lanes {23, -24, 2047, -2064, 0, 8, -8, 100000}: bytes {1, -1, 127, -128, 0, 1, 0, 127}, sat_flag=1.
- Burst of 9 rows (matrix_index 0..8), data_set=1, ready=1: addrs 9..17 in order, one write per cycle, no drops.
- Backpressure: ready=0 during 6 consecutive rows: first 4 queued (fifo_level=4), rows 5 and 6 dropped, overflow_err=1. Then ready=1: exactly 4 writes, addr/data stable across each stall.
- Full FIFO with simultaneous push and pop (ready=1 on the cycle a 5th row arrives): no drop, level stays 4, overflow_err=0.
- tpu_done while 3 entries are pending and ready toggles 1/0: wb_done pulses exactly once, in the cycle after the last pop. Asserting srstn=0 mid-burst leaves wen=0 and level=0 next cycle, and no wb_done.
